// File: rtl/t03_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch/PC sequencer.
// No logic; no latency.
// No flow control of its own.
package t03_fetch_pkg;

  // Sequencer states; HALT is absorbing until reset
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Bit positions inside the branch-control vector
  localparam int CTRL_JALR  = 0;
  localparam int CTRL_TAKEN = 1;

  // Size of one instruction in bytes
  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/t03_fetch_sequencer_next_pc.sv
// Next-PC target mux: register-indirect, pc-relative or sequential.
// Purely combinational, zero cycles.
// No flow control; the caller decides when the target is consumed.
module t03_next_pc
  import t03_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      ctrl,
  input  logic [XLEN-1:0] imm_offset,
  input  logic [XLEN-1:0] jalr_target,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] rel_pc;

  // Both adders wrap modulo 2^XLEN; wrap is not an error by itself
  assign seq_pc = pc + XLEN'(INSTR_BYTES);
  assign rel_pc = pc + imm_offset;

  // Register-indirect wins over taken when both bits are set
  always_comb begin
    target = seq_pc;
    if (ctrl[CTRL_JALR]) begin
      target = {jalr_target[XLEN-1:1], 1'b0};
    end else if (ctrl[CTRL_TAKEN]) begin
      target = rel_pc;
    end
  end

  // Only bit1 flags misalignment; bit0 is cleared for indirect jumps
  assign misaligned = target[1];

endmodule

// File: rtl/t03_fetch_sequencer.sv
// Multi-cycle fetch/PC sequencer: request word, hold it through execute, update PC.
// Min one FETCH cycle plus one EXEC cycle per instruction.
// Fetch request held stable until imem_ack; EXEC waits for exec_done.
module t03_fetch_sequencer
  import t03_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            exec_done,
  input  logic [1:0]      ctrl,
  input  logic [XLEN-1:0] imm_offset,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fault
);

  state_t          state;
  logic [XLEN-1:0] target;
  logic            misaligned;

  t03_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc          (pc),
    .ctrl        (ctrl),
    .imm_offset  (imm_offset),
    .jalr_target (jalr_target),
    .target      (target),
    .misaligned  (misaligned)
  );

  // Request is decoded from state so reset drops it immediately
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(INSTR_BYTES);

  // Sequencer FSM with PC, instruction and sticky fault registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (en) state <= ST_FETCH;
        end
        ST_FETCH: begin
          // en is deliberately ignored: an outstanding request always completes
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              fault <= 1'b1;
              state <= ST_HALT;
            end else begin
              pc    <= target;
              state <= en ? ST_FETCH : ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t03_fetch_sequencer.sv
module tb_t03_fetch_sequencer;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic [1:0]  ctrl;
  logic [31:0] imm_offset;
  logic [31:0] jalr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int n_chk = 0;
  int n_err = 0;

  t03_fetch_sequencer #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .exec_done   (exec_done),
    .ctrl        (ctrl),
    .imm_offset  (imm_offset),
    .jalr_target (jalr_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] jalr;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] cur_pc;
    logic [31:0] word;

    vecs[0]  = '{2'b11, 32'h0000_0000, 32'h0000_0101, 32'h0000_0100};
    vecs[1]  = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_00F8};
    vecs[2]  = '{2'b11, 32'h0000_0040, 32'h0000_0100, 32'h0000_0100};
    vecs[3]  = '{2'b00, 32'h0000_0020, 32'h0000_0008, 32'h0000_0104};
    vecs[4]  = '{2'b01, 32'h0000_0000, 32'h0000_2001, 32'h0000_2000};
    vecs[5]  = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[6]  = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
    vecs[8]  = '{2'b10, 32'h0000_0008, 32'h0000_0000, 32'h0000_0004};
    vecs[9]  = '{2'b10, 32'h0000_0010, 32'h0000_0000, 32'h0000_0014};
    vecs[10] = '{2'b10, 32'hFFFF_FFEC, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{2'b10, 32'h7FFF_FFF0, 32'h0000_0003, 32'h7FFF_FFF0};

    nrst = 1'b0; en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; ctrl = 2'b00; imm_offset = '0; jalr_target = '0;

    // Reset state
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    nrst = 1'b1;

    // First instruction: ack arrives in the second FETCH cycle
    step();
    chk("idle_no_req", {31'b0, imem_req}, 32'h0);
    en = 1'b1;
    step();
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_valid_fetch", {31'b0, instr_valid}, 32'h0);
    step();
    chk("t1_req_held", {31'b0, imem_req}, 32'h1);
    chk("t1_addr_held", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_ack = 1'b0;
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_valid_exec", {31'b0, instr_valid}, 32'h1);
    chk("t1_req_exec", {31'b0, imem_req}, 32'h0);
    // Stray ack during EXEC must not touch instr
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("t1_instr_hold", instr, 32'h0050_0093);
    chk("t1_valid_hold", {31'b0, instr_valid}, 32'h1);
    exec_done = 1'b1; ctrl = 2'b00;
    step();
    exec_done = 1'b0;
    chk("t1_addr_next", imem_addr, 32'h4);
    chk("t1_req_next", {31'b0, imem_req}, 32'h1);
    chk("t1_valid_off", {31'b0, instr_valid}, 32'h0);

    // Table-driven instructions, each fetched with single-cycle ack
    cur_pc = 32'h4;
    for (int i = 0; i < 12; i++) begin
      word = 32'h1000_0000 + 32'(i);
      chk($sformatf("v%0d_addr", i), imem_addr, cur_pc);
      imem_ack = 1'b1; imem_rdata = word;
      step();
      imem_ack = 1'b0;
      chk($sformatf("v%0d_instr", i), instr, word);
      chk($sformatf("v%0d_plus4", i), pc_plus4, cur_pc + 32'h4);
      exec_done = 1'b1; ctrl = vecs[i].ctrl;
      imm_offset = vecs[i].imm; jalr_target = vecs[i].jalr;
      step();
      exec_done = 1'b0;
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_fault", i), {31'b0, fault}, 32'h0);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'h0);
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'h1);
      cur_pc = vecs[i].exp_pc;
    end

    // en dropped mid-FETCH: request still completes, then IDLE
    en = 1'b0;
    step();
    chk("t5_req_held", {31'b0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    chk("t5_valid", {31'b0, instr_valid}, 32'h1);
    exec_done = 1'b1; ctrl = 2'b00;
    step();
    exec_done = 1'b0;
    chk("t5_pc", pc, 32'h7FFF_FFF4);
    // Stray ack and exec_done in IDLE are ignored
    imem_ack = 1'b1; exec_done = 1'b1; ctrl = 2'b11; jalr_target = 32'h40;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_idle_req%0d", k), {31'b0, imem_req}, 32'h0);
      chk($sformatf("t5_idle_pc%0d", k), pc, 32'h7FFF_FFF4);
    end
    imem_ack = 1'b0; exec_done = 1'b0;
    chk("t5_idle_instr", instr, 32'h0000_0013);

    // Misaligned indirect target: fault and HALT
    en = 1'b1;
    step();
    chk("t3_req", {31'b0, imem_req}, 32'h1);
    chk("t3_addr", imem_addr, 32'h7FFF_FFF4);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    exec_done = 1'b1; ctrl = 2'b11; jalr_target = 32'h0000_2002;
    step();
    exec_done = 1'b0;
    chk("t3_fault", {31'b0, fault}, 32'h1);
    chk("t3_pc_kept", pc, 32'h7FFF_FFF4);
    chk("t3_valid", {31'b0, instr_valid}, 32'h0);
    imem_ack = 1'b1; exec_done = 1'b1; ctrl = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3_halt_req%0d", k), {31'b0, imem_req}, 32'h0);
      chk($sformatf("t3_halt_fault%0d", k), {31'b0, fault}, 32'h1);
    end
    imem_ack = 1'b0; exec_done = 1'b0;

    // Reset leaves HALT; then reset again in the middle of a FETCH
    nrst = 1'b0;
    #1;
    chk("t6_rst_fault", {31'b0, fault}, 32'h0);
    chk("t6_rst_pc", pc, 32'h0);
    nrst = 1'b1;
    step();
    chk("t6_fetch_req", {31'b0, imem_req}, 32'h1);
    chk("t6_fetch_addr", imem_addr, 32'h0);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_req_drop", {31'b0, imem_req}, 32'h0);
    chk("t6_pc", pc, 32'h0);
    en = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    #1;
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_late_req%0d", k), {31'b0, imem_req}, 32'h0);
      chk($sformatf("t6_late_valid%0d", k), {31'b0, instr_valid}, 32'h0);
      chk($sformatf("t6_late_instr%0d", k), instr, 32'h0);
    end
    imem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected end before limit");
    $fatal(1, "timeout");
  end

endmodule
